// File: rtl/move_referee.sv
// Tic-tac-toe referee: validates move requests, commits them to the board and scores the game.
// Latency: valid/reject 1 cycle after the check edge, board at +2, outcome/done at +3; no backpressure.
module move_referee #(
    parameter logic [1:0] P1_CODE         = 2'b01,
    parameter logic [1:0] P2_CODE         = 2'b10,
    parameter logic [2:0] OUT_IN_PROGRESS = 3'd0,
    parameter logic [2:0] OUT_P1_WIN      = 3'd1,
    parameter logic [2:0] OUT_P1_LOSE     = 3'd2,
    parameter logic [2:0] OUT_TIE         = 3'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       check,
    input  logic [3:0] move,
    input  logic [1:0] user,
    output logic       valid,
    output logic       reject,
    output logic [2:0] outcome,
    output logic [8:0] board_p1,
    output logic [8:0] board_p2,
    output logic [3:0] move_count,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_SCORE  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_check_d;
    logic [8:0]  r_mask;
    logic [1:0]  r_user;
    logic        r_valid;
    logic        r_reject;
    logic        r_done;
    logic [2:0]  r_outcome;
    logic [8:0]  r_b1;
    logic [8:0]  r_b2;
    logic [3:0]  r_count;

    logic        w_req;
    logic        w_in_range;
    logic [8:0]  w_mask;
    logic        w_cell_free;
    logic        w_user_ok;
    logic        w_legal;

    // Bit i-1 of a board is cell i; rows, columns, then the two diagonals.
    function automatic logic has_line(input logic [8:0] b);
        logic r;
        r = (&{b[0], b[1], b[2]}) | (&{b[3], b[4], b[5]}) | (&{b[6], b[7], b[8]})
          | (&{b[0], b[3], b[6]}) | (&{b[1], b[4], b[7]}) | (&{b[2], b[5], b[8]})
          | (&{b[0], b[4], b[8]}) | (&{b[2], b[4], b[6]});
        return r;
    endfunction

    assign w_req       = check & ~r_check_d;
    assign w_in_range  = (move >= 4'd1) && (move <= 4'd9);
    assign w_mask      = w_in_range ? (9'd1 << (move - 4'd1)) : 9'd0;
    assign w_cell_free = ((r_b1 | r_b2) & w_mask) == 9'd0;
    assign w_user_ok   = (user == P1_CODE) || (user == P2_CODE);
    assign w_legal     = w_in_range && w_cell_free && w_user_ok
                         && (r_outcome == OUT_IN_PROGRESS);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_check_d <= 1'b0;
            r_mask    <= 9'd0;
            r_user    <= 2'd0;
            r_valid   <= 1'b0;
            r_reject  <= 1'b0;
            r_done    <= 1'b0;
            r_outcome <= OUT_IN_PROGRESS;
            r_b1      <= 9'd0;
            r_b2      <= 9'd0;
            r_count   <= 4'd0;
        end else begin
            // The edge detector keeps tracking even through start, so a held check never replays.
            r_check_d <= check;
            if (start) begin
                r_state   <= ST_IDLE;
                r_valid   <= 1'b0;
                r_reject  <= 1'b0;
                r_done    <= 1'b0;
                r_outcome <= OUT_IN_PROGRESS;
                r_b1      <= 9'd0;
                r_b2      <= 9'd0;
                r_count   <= 4'd0;
            end else begin
                r_valid  <= 1'b0;
                r_reject <= 1'b0;
                r_done   <= 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        if (w_req) begin
                            r_mask <= w_mask;
                            r_user <= user;
                            if (w_legal) begin
                                r_valid <= 1'b1;
                                r_state <= ST_COMMIT;
                            end else begin
                                r_reject <= 1'b1;
                            end
                        end
                    end
                    ST_COMMIT: begin
                        if (r_user == P1_CODE) begin
                            r_b1 <= r_b1 | r_mask;
                        end else begin
                            r_b2 <= r_b2 | r_mask;
                        end
                        if (r_count != 4'd9) begin
                            r_count <= r_count + 4'd1;
                        end
                        r_state <= ST_SCORE;
                    end
                    ST_SCORE: begin
                        // Wins are checked before the full-board tie.
                        if (has_line(r_b1)) begin
                            r_outcome <= OUT_P1_WIN;
                        end else if (has_line(r_b2)) begin
                            r_outcome <= OUT_P1_LOSE;
                        end else if (r_count == 4'd9) begin
                            r_outcome <= OUT_TIE;
                        end else begin
                            r_outcome <= OUT_IN_PROGRESS;
                        end
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign valid      = r_valid;
    assign reject     = r_reject;
    assign done       = r_done;
    assign outcome    = r_outcome;
    assign board_p1   = r_b1;
    assign board_p2   = r_b2;
    assign move_count = r_count;

endmodule

// File: tb/tb_move_referee.sv
// Scoreboard bench for move_referee: stimulus pushes expected valid/reject/done events, a monitor pops and compares.
module tb_move_referee;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       check;
    logic [3:0] move;
    logic [1:0] user;
    logic       valid;
    logic       reject;
    logic [2:0] outcome;
    logic [8:0] board_p1;
    logic [8:0] board_p2;
    logic [3:0] move_count;
    logic       done;

    move_referee dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .check      (check),
        .move       (move),
        .user       (user),
        .valid      (valid),
        .reject     (reject),
        .outcome    (outcome),
        .board_p1   (board_p1),
        .board_p2   (board_p2),
        .move_count (move_count),
        .done       (done)
    );

    always #5 clk = ~clk;

    localparam int K_VALID = 0;
    localparam int K_REJ   = 1;
    localparam int K_DONE  = 2;

    typedef struct {
        int         kind;
        int         cyc;
        logic [8:0] b1;
        logic [8:0] b2;
        logic [3:0] cnt;
        logic [2:0] out;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [8:0] m_b1;
    logic [8:0] m_b2;
    logic [3:0] m_cnt;
    logic [2:0] m_out;

    always @(posedge clk) cyc <= cyc + 1;

    int   mon_kind;
    int   mon_nev;
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst === 1'b1 && (valid || reject || done)) begin
            mon_nev  = int'(valid) + int'(reject) + int'(done);
            mon_kind = valid ? K_VALID : (reject ? K_REJ : K_DONE);
            n_checks++;
            if (mon_nev > 1) begin
                n_fail++;
                $display("FAIL exclusive_pulses cyc=%0d: valid=%0b reject=%0b done=%0b, required at most one",
                         cyc, valid, reject, done);
            end else if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event cyc=%0d: kind=%0d seen, required none", cyc, mon_kind);
            end else begin
                mon_e = q.pop_front();
                if (mon_kind != mon_e.kind || cyc != mon_e.cyc || board_p1 != mon_e.b1
                    || board_p2 != mon_e.b2 || move_count != mon_e.cnt || outcome != mon_e.out) begin
                    n_fail++;
                    $display("FAIL event: got kind=%0d cyc=%0d p1=%h p2=%h cnt=%0d out=%0d, required kind=%0d cyc=%0d p1=%h p2=%h cnt=%0d out=%0d",
                             mon_kind, cyc, board_p1, board_p2, move_count, outcome,
                             mon_e.kind, mon_e.cyc, mon_e.b1, mon_e.b2, mon_e.cnt, mon_e.out);
                end
            end
        end
    end

    task automatic push(input int kind, input int c);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        e.b1   = m_b1;
        e.b2   = m_b2;
        e.cnt  = m_cnt;
        e.out  = m_out;
        q.push_back(e);
    endtask

    task automatic check_state(input string name, input logic [8:0] b1, input logic [8:0] b2,
                               input logic [3:0] cnt, input logic [2:0] out);
        n_checks++;
        if (board_p1 !== b1 || board_p2 !== b2 || move_count !== cnt || outcome !== out
            || valid !== 1'b0 || reject !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: p1=%h p2=%h cnt=%0d out=%0d v/r/d=%b%b%b, required p1=%h p2=%h cnt=%0d out=%0d v/r/d=000",
                     name, board_p1, board_p2, move_count, outcome, valid, reject, done, b1, b2, cnt, out);
        end
    endtask

    task automatic new_game();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_b1 = 9'd0; m_b2 = 9'd0; m_cnt = 4'd0; m_out = 3'd0;
    endtask

    // legal/exp_out are hand-computed per vector; the model only tracks board bits and the count.
    task automatic req(input logic [3:0] m, input logic [1:0] u, input bit legal,
                       input logic [2:0] exp_out, input int hold);
        int c;
        @(negedge clk);
        c     = cyc;
        move  = m;
        user  = u;
        check = 1'b1;
        if (legal) begin
            push(K_VALID, c + 1);
            if (u == 2'b01) m_b1[m - 4'd1] = 1'b1;
            else            m_b2[m - 4'd1] = 1'b1;
            m_cnt = m_cnt + 4'd1;
            m_out = exp_out;
            push(K_DONE, c + 3);
        end else begin
            push(K_REJ, c + 1);
        end
        repeat (hold) @(negedge clk);
        check = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; check = 1'b0; move = 4'd0; user = 2'd0;
        m_b1 = 9'd0; m_b2 = 9'd0; m_cnt = 4'd0; m_out = 3'd0;
        repeat (2) @(negedge clk);
        check_state("reset", 9'h000, 9'h000, 4'd0, 3'd0);
        rst = 1'b1;
        new_game();
        check_state("after_start", 9'h000, 9'h000, 4'd0, 3'd0);

        req(4'd5,  2'b01, 1, 3'd0, 1);
        check_state("p1_center", 9'h010, 9'h000, 4'd1, 3'd0);
        req(4'd5,  2'b10, 0, 3'd0, 1);
        req(4'd0,  2'b01, 0, 3'd0, 1);
        req(4'd10, 2'b01, 0, 3'd0, 1);
        req(4'd1,  2'b11, 0, 3'd0, 1);
        check_state("after_illegal", 9'h010, 9'h000, 4'd1, 3'd0);
        req(4'd1,  2'b01, 1, 3'd0, 5);
        check_state("held_check", 9'h011, 9'h000, 4'd2, 3'd0);

        new_game();
        req(4'd1, 2'b01, 1, 3'd0, 1);
        req(4'd4, 2'b10, 1, 3'd0, 1);
        req(4'd2, 2'b01, 1, 3'd0, 1);
        req(4'd5, 2'b10, 1, 3'd0, 1);
        req(4'd3, 2'b01, 1, 3'd1, 1);
        req(4'd9, 2'b10, 0, 3'd0, 1);
        check_state("row_win", 9'h007, 9'h018, 4'd5, 3'd1);

        new_game();
        req(4'd1, 2'b01, 1, 3'd0, 1);
        req(4'd2, 2'b10, 1, 3'd0, 1);
        req(4'd3, 2'b01, 1, 3'd0, 1);
        req(4'd5, 2'b10, 1, 3'd0, 1);
        req(4'd4, 2'b01, 1, 3'd0, 1);
        req(4'd6, 2'b10, 1, 3'd0, 1);
        req(4'd8, 2'b01, 1, 3'd0, 1);
        req(4'd7, 2'b10, 1, 3'd0, 1);
        req(4'd9, 2'b01, 1, 3'd3, 1);
        req(4'd5, 2'b10, 0, 3'd0, 1);
        check_state("tie", 9'h18D, 9'h072, 4'd9, 3'd3);

        new_game();
        req(4'd1, 2'b01, 1, 3'd0, 1);
        req(4'd3, 2'b10, 1, 3'd0, 1);
        req(4'd2, 2'b01, 1, 3'd0, 1);
        req(4'd4, 2'b10, 1, 3'd0, 1);
        req(4'd5, 2'b01, 1, 3'd0, 1);
        req(4'd7, 2'b10, 1, 3'd0, 1);
        req(4'd6, 2'b01, 1, 3'd0, 1);
        req(4'd8, 2'b10, 1, 3'd0, 1);
        req(4'd9, 2'b01, 1, 3'd1, 1);
        check_state("diag_win_9th", 9'h133, 9'h0CC, 4'd9, 3'd1);

        new_game();
        begin
            int c;
            @(negedge clk);
            c = cyc;
            move = 4'd5; user = 2'b01; check = 1'b1;
            push(K_VALID, c + 1);
            @(negedge clk);
            check = 1'b0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (3) @(negedge clk);
        end
        check_state("start_in_commit", 9'h000, 9'h000, 4'd0, 3'd0);
        req(4'd5, 2'b01, 1, 3'd0, 1);
        check_state("after_abort", 9'h010, 9'h000, 4'd1, 3'd0);

        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events: %0d expected events never seen, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/move_referee.md
Name: move_referee

Overview:
- Referee side of the tic-tac-toe turn handshake. Answers each move request with a `valid` decision and keeps `outcome` up to date.
- The turn-system FSM supplies `move`, `check` and `user`, samples `valid` one cycle after raising `check`, and samples `outcome` two cycles after that.
- The block owns the authoritative board: occupancy per player, move count, and win/tie detection over the 8 lines.

Parameters:
- P1_CODE, 2'b01: `user` value identifying player 1.
- P2_CODE, 2'b10: `user` value identifying player 2.
- OUT_IN_PROGRESS, 3'd0: outcome, game in progress.
- OUT_P1_WIN, 3'd1: outcome, player 1 wins.
- OUT_P1_LOSE, 3'd2: outcome, player 2 wins.
- OUT_TIE, 3'd3: outcome, tie.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset; synchronous, active-low (rst==0 at a clk edge resets).
- start  in  1  level; clears the board and begins a new game.
- check  in  1  move request; the rising edge is detected internally.
- move  in  4  cell index: 1..9 = A1,A2,A3,B1,B2,B3,C1,C2,C3; 0 and 10..15 are illegal.
- user  in  2  requesting player (P1_CODE / P2_CODE).
- valid  out  1  one-cycle pulse: the request was legal and is being committed.
- reject  out  1  one-cycle pulse: the request was illegal; board unchanged.
- outcome  out  3  registered game result (encodings above).
- board_p1  out  9  bit i-1 set = cell i owned by P1.
- board_p2  out  9  bit i-1 set = cell i owned by P2.
- move_count  out  4  number of committed moves, 0..9.
- done  out  1  one-cycle pulse when `outcome` has been refreshed after a commit.

Behaviour:
- Reset (rst==0 at edge): state IDLE; all outputs 0; board_p1 = board_p2 = 9'h000; edge-detector register cleared.
- Priority at each edge: rst, then start, then FSM.
- start==1: board, move_count, outcome, valid, reject and done all go to 0; state goes to IDLE. Applies in any state, including mid-evaluation; a pending commit is discarded.
- Edge detector: `check_d` is updated every cycle. A request is `check & ~check_d`. A held-high `check` yields only one request.
- State IDLE, on a request:
  - Latch `move` and `user`.
  - Legal iff all hold: move is in 1..9; the cell is clear in both boards; user == P1_CODE or P2_CODE; outcome == OUT_IN_PROGRESS.
  - If legal: valid<=1, state goes to COMMIT.
  - If illegal: reject<=1, state stays IDLE.
- State COMMIT (1 cycle):
  - Set the latched cell bit in the latched user's board.
  - move_count += 1.
  - valid and reject are 0.
  - State goes to SCORE.
- State SCORE (1 cycle):
  - outcome <= OUT_P1_WIN if board_p1 holds any of the 8 lines; else OUT_P1_LOSE if board_p2 does; else OUT_TIE if move_count==9; else OUT_IN_PROGRESS.
  - done<=1; state goes to IDLE.
- Lines: three rows, three columns, two diagonals (A1-B2-C3, A3-B2-C1).
- Win beats tie: if the 9th move completes a line, the result is a win, not a tie.
- Timing contract. Request seen at edge E0:
  - valid/reject visible during the cycle after E0.
  - Board updated at E1.
  - outcome and done valid after E2, i.e. by the turn FSM's CHECK state.
- A request arriving in COMMIT or SCORE is dropped (no valid, no reject). The edge detector still advances, so it is not replayed.
- Once outcome != 0, every further request is rejected until start.
- move_count saturates at 9. It cannot exceed 9 because a full board makes every cell occupied, so requests are rejected.
- valid, reject and done are never asserted together.

Test Plan:
- Reset with rst=0 for 2 cycles -> all outputs 0, boards 9'h000. Then start=1 for 1 cycle -> still 0.
- P1 requests move=5 (check pulse, user=01) -> valid=1 exactly 1 cycle after the edge; board_p1=9'h010 after the next edge; outcome=0 and done=1 one cycle later; move_count=1.
- P2 requests move=5 after the above -> reject=1 and valid=0; board_p2 unchanged at 9'h000; move_count=1.
- Illegal requests: move=0, move=10, and user=2'b11 -> each gives reject=1, no state change. check held high 5 cycles with move=1 -> exactly one valid.
- P1 plays 1,2,3 interleaved with P2 plays 4,5 -> after the 3rd P1 commit, outcome=3'd1. A later request (P2 move=9) -> reject=1.
- Full-board draw, P1: 1,3,4,8,9 and P2: 2,5,6,7 -> outcome=3'd3, move_count=9.
- P1 completes the diagonal on the 9th move -> outcome=3'd1, not 3'd3.
- Assert start during COMMIT -> no board bit set, outcome=0, state IDLE.
